// File: rtl/axi4_lite_mem_q.sv
// AXI4-Lite slave memory: queued AR/AW/W channels, programmable read latency,
// SLVERR on unmapped addresses, console byte port. `AXI_MEM_STALL_EN adds LFSR stalls.
module axi4_lite_mem_q #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       MEM_BYTES    = 65536,
  parameter int unsigned       RD_QDEPTH    = 4,
  parameter int unsigned       WR_QDEPTH    = 4,
  parameter int unsigned       RD_LATENCY   = 0,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(32'h1000_0000),
  parameter string             INIT_FILE    = ""
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [2:0]          awprot,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [2:0]          arprot,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                cons_valid,
  output logic [7:0]          cons_data
);
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned OFF_W     = $clog2(STRB_W);
  localparam int unsigned MEM_WORDS = MEM_BYTES / STRB_W;
  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned RP_W      = (RD_QDEPTH > 1) ? $clog2(RD_QDEPTH) : 1;
  localparam int unsigned WP_W      = (WR_QDEPTH > 1) ? $clog2(WR_QDEPTH) : 1;
  localparam int unsigned RC_W      = $clog2(RD_QDEPTH + 1);
  localparam int unsigned WC_W      = $clog2(WR_QDEPTH + 1);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b10;

  typedef enum logic [1:0] {DEC_MEM, DEC_CONS, DEC_ERR} dec_e;

  function automatic dec_e decode(input logic [ADDR_W-1:0] a);
    if (a < ADDR_W'(MEM_BYTES)) return DEC_MEM;
    else if (a == CONSOLE_ADDR) return DEC_CONS;
    else                        return DEC_ERR;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [RP_W-1:0] rd_inc(input logic [RP_W-1:0] p);
    return (p == RP_W'(RD_QDEPTH - 1)) ? '0 : p + RP_W'(1);
  endfunction

  function automatic logic [WP_W-1:0] wr_inc(input logic [WP_W-1:0] p);
    return (p == WP_W'(WR_QDEPTH - 1)) ? '0 : p + WP_W'(1);
  endfunction

  logic [DATA_W-1:0] mem      [MEM_WORDS];
  logic [ADDR_W-1:0] rdq_addr [RD_QDEPTH];
  logic              rdq_insn [RD_QDEPTH];
  logic [ADDR_W-1:0] awq_addr [WR_QDEPTH];
  logic [DATA_W-1:0] wq_data  [WR_QDEPTH];
  logic [STRB_W-1:0] wq_strb  [WR_QDEPTH];

  logic [RP_W-1:0]   rd_head_q, rd_head_d, rd_tail_q, rd_tail_d;
  logic [RC_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [WP_W-1:0]   aw_head_q, aw_head_d, aw_tail_q, aw_tail_d;
  logic [WC_W-1:0]   aw_cnt_q, aw_cnt_d;
  logic [WP_W-1:0]   w_head_q, w_head_d, w_tail_q, w_tail_d;
  logic [WC_W-1:0]   w_cnt_q, w_cnt_d;
  logic [3:0]        lat_q, lat_d;
  logic              rvalid_q, rvalid_d, bvalid_q, bvalid_d, cons_valid_q, cons_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d, bresp_q, bresp_d;
  logic [7:0]        cons_data_q, cons_data_d;

  logic              ar_push, aw_push, w_push, rd_issue, wr_commit, lat_done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  dec_e              rd_dec, wr_dec;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [4:0]        stall_ok;

`ifdef AXI_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_ok = lfsr_q[4:0];
  end
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  always_comb stall_ok = '1;
`endif

  always_comb begin
    arready   = resetn && (rd_cnt_q != RC_W'(RD_QDEPTH)) && stall_ok[0];
    awready   = resetn && (aw_cnt_q != WC_W'(WR_QDEPTH)) && stall_ok[1];
    wready    = resetn && (w_cnt_q  != WC_W'(WR_QDEPTH)) && stall_ok[2];
    ar_push   = arvalid && arready;
    aw_push   = awvalid && awready;
    w_push    = wvalid && wready;

    rd_addr   = rdq_addr[rd_head_q];
    rd_dec    = decode(rd_addr);
    lat_done  = (lat_q == 4'(RD_LATENCY));
    rd_issue  = resetn && (rd_cnt_q != '0) && lat_done && (!rvalid_q || rready) && stall_ok[3];

    wr_addr   = awq_addr[aw_head_q];
    wr_dec    = decode(wr_addr);
    wr_idx    = word_idx(wr_addr);
    wr_data   = wq_data[w_head_q];
    wr_strb   = wq_strb[w_head_q];
    wr_commit = resetn && (aw_cnt_q != '0) && (w_cnt_q != '0) && (!bvalid_q || bready) && stall_ok[4];

    rd_head_d = rd_issue ? rd_inc(rd_head_q) : rd_head_q;
    rd_tail_d = ar_push ? rd_inc(rd_tail_q) : rd_tail_q;
    rd_cnt_d  = rd_cnt_q + RC_W'(ar_push) - RC_W'(rd_issue);
    aw_head_d = wr_commit ? wr_inc(aw_head_q) : aw_head_q;
    aw_tail_d = aw_push ? wr_inc(aw_tail_q) : aw_tail_q;
    aw_cnt_d  = aw_cnt_q + WC_W'(aw_push) - WC_W'(wr_commit);
    w_head_d  = wr_commit ? wr_inc(w_head_q) : w_head_q;
    w_tail_d  = w_push ? wr_inc(w_tail_q) : w_tail_q;
    w_cnt_d   = w_cnt_q + WC_W'(w_push) - WC_W'(wr_commit);

    // Latency counts per queue head; it restarts for each new head after a pop
    lat_d = lat_q;
    if (rd_issue)                         lat_d = '0;
    else if (rd_cnt_q != '0 && !lat_done) lat_d = lat_q + 4'd1;

    rvalid_d = rvalid_q && !rready;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rd_issue) begin
      rvalid_d = 1'b1;
      rdata_d  = (rd_dec == DEC_MEM) ? mem[word_idx(rd_addr)] : '0;
      rresp_d  = (rd_dec == DEC_ERR) ? RESP_ERR : RESP_OKAY;
    end

    bvalid_d     = bvalid_q && !bready;
    bresp_d      = bresp_q;
    cons_valid_d = 1'b0;
    cons_data_d  = cons_data_q;
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_dec == DEC_ERR) ? RESP_ERR : RESP_OKAY;
      if (wr_dec == DEC_CONS && wr_strb[0]) begin
        cons_valid_d = 1'b1;
        cons_data_d  = wr_data[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_head_q    <= '0;
      rd_tail_q    <= '0;
      rd_cnt_q     <= '0;
      aw_head_q    <= '0;
      aw_tail_q    <= '0;
      aw_cnt_q     <= '0;
      w_head_q     <= '0;
      w_tail_q     <= '0;
      w_cnt_q      <= '0;
      lat_q        <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      cons_valid_q <= 1'b0;
      cons_data_q  <= '0;
    end else begin
      rd_head_q    <= rd_head_d;
      rd_tail_q    <= rd_tail_d;
      rd_cnt_q     <= rd_cnt_d;
      aw_head_q    <= aw_head_d;
      aw_tail_q    <= aw_tail_d;
      aw_cnt_q     <= aw_cnt_d;
      w_head_q     <= w_head_d;
      w_tail_q     <= w_tail_d;
      w_cnt_q      <= w_cnt_d;
      lat_q        <= lat_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      cons_valid_q <= cons_valid_d;
      cons_data_q  <= cons_data_d;
    end
  end

  // Storage arrays carry no reset; a read issued on a commit edge sees the old word
  always_ff @(posedge clk) begin
    if (ar_push) begin
      rdq_addr[rd_tail_q] <= araddr;
      rdq_insn[rd_tail_q] <= arprot[2];
    end
    if (aw_push) awq_addr[aw_tail_q] <= awaddr;
    if (w_push) begin
      wq_data[w_tail_q] <= wdata;
      wq_strb[w_tail_q] <= wstrb;
    end
    if (wr_commit && wr_dec == DEC_MEM) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_comb begin
    rvalid     = rvalid_q;
    rdata      = rdata_q;
    rresp      = rresp_q;
    bvalid     = bvalid_q;
    bresp      = bresp_q;
    cons_valid = cons_valid_q;
    cons_data  = cons_data_q;
  end

  logic unused_inputs;
  always_comb unused_inputs = ^{awprot, arprot[1:0], rdq_insn[rd_head_q]};
endmodule
